// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared sizes and encodings for the Segre core
package segre_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ADDR_SIZE = 32;
  localparam int REG_SIZE  = 5;

  typedef enum logic [2:0] {
    IF_STATE,
    ID_STATE,
    EX_STATE,
    MEM_STATE,
    WB_STATE
  } fsm_state_e;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_LUI,
    ALU_BEQ,
    ALU_BNE,
    ALU_BLT,
    ALU_BGE,
    ALU_BLTU,
    ALU_BGEU,
    ALU_JAL,
    ALU_JALR
  } alu_opcode_e;

  typedef enum logic [1:0] {
    MEMOP_BYTE,
    MEMOP_HALF,
    MEMOP_WORD
  } memop_data_type_e;

endpackage

// File: rtl/segre_ex_stage_if.sv
// rtl/segre_ex_stage_if.sv - decode-to-execute bundle and execute results
interface segre_ex_stage_if
  import segre_pkg::*;
();

  fsm_state_e             fsm_state_i;
  alu_opcode_e            alu_opcode_i;
  logic [WORD_SIZE-1:0]   alu_src_a_i;
  logic [WORD_SIZE-1:0]   alu_src_b_i;
  logic [WORD_SIZE-1:0]   br_src_a_i;
  logic [WORD_SIZE-1:0]   br_src_b_i;
  logic                   rf_we_i;
  logic [REG_SIZE-1:0]    rf_waddr_i;
  memop_data_type_e       memop_type_i;
  logic                   memop_sign_ext_i;
  logic                   memop_rd_i;
  logic                   memop_wr_i;
  logic [WORD_SIZE-1:0]   memop_rf_data_i;
  logic                   is_jaljalr_i;
  logic [ADDR_SIZE-1:0]   seq_new_pc_i;

  logic [WORD_SIZE-1:0]   alu_res_o;
  logic                   rf_we_o;
  logic [REG_SIZE-1:0]    rf_waddr_o;
  memop_data_type_e       memop_type_o;
  logic                   memop_sign_ext_o;
  logic                   memop_rd_o;
  logic                   memop_wr_o;
  logic [WORD_SIZE-1:0]   memop_rf_data_o;
  logic                   tkbr_o;
  logic [ADDR_SIZE-1:0]   new_pc_o;

  modport master (
    output fsm_state_i, alu_opcode_i, alu_src_a_i, alu_src_b_i, br_src_a_i, br_src_b_i,
           rf_we_i, rf_waddr_i, memop_type_i, memop_sign_ext_i, memop_rd_i, memop_wr_i,
           memop_rf_data_i, is_jaljalr_i, seq_new_pc_i,
    input  alu_res_o, rf_we_o, rf_waddr_o, memop_type_o, memop_sign_ext_o, memop_rd_o,
           memop_wr_o, memop_rf_data_o, tkbr_o, new_pc_o
  );

  modport slave (
    input  fsm_state_i, alu_opcode_i, alu_src_a_i, alu_src_b_i, br_src_a_i, br_src_b_i,
           rf_we_i, rf_waddr_i, memop_type_i, memop_sign_ext_i, memop_rd_i, memop_wr_i,
           memop_rf_data_i, is_jaljalr_i, seq_new_pc_i,
    output alu_res_o, rf_we_o, rf_waddr_o, memop_type_o, memop_sign_ext_o, memop_rd_o,
           memop_wr_o, memop_rf_data_o, tkbr_o, new_pc_o
  );

endinterface

// File: rtl/segre_ex_stage.sv
// rtl/segre_ex_stage.sv - execute stage: ALU, branch resolution, EX/MEM pipeline register
module segre_ex_stage
  import segre_pkg::*;
(
  input logic               clk_i,
  input logic               rsn_i,
  segre_ex_stage_if.slave   ex
);

  logic [WORD_SIZE-1:0] alu_res;
  logic [WORD_SIZE-1:0] sum;
  logic [ADDR_SIZE-1:0] target;
  logic                 taken;
  logic                 br_eq;
  logic                 br_lt;
  logic                 br_ltu;

  logic [WORD_SIZE-1:0] alu_res_d, alu_res_q;
  logic                 rf_we_d, rf_we_q;
  logic [REG_SIZE-1:0]  rf_waddr_d, rf_waddr_q;
  memop_data_type_e     memop_type_d, memop_type_q;
  logic                 memop_sign_ext_d, memop_sign_ext_q;
  logic                 memop_rd_d, memop_rd_q;
  logic                 memop_wr_d, memop_wr_q;
  logic [WORD_SIZE-1:0] memop_rf_data_d, memop_rf_data_q;
  logic                 tkbr_d, tkbr_q;
  logic [ADDR_SIZE-1:0] new_pc_d, new_pc_q;

  assign sum    = ex.alu_src_a_i + ex.alu_src_b_i;
  assign br_eq  = (ex.br_src_a_i == ex.br_src_b_i);
  assign br_lt  = ($signed(ex.br_src_a_i) < $signed(ex.br_src_b_i));
  assign br_ltu = (ex.br_src_a_i < ex.br_src_b_i);

  always_comb begin
    alu_res = '0;
    taken   = 1'b0;
    target  = sum;
    case (ex.alu_opcode_i)
      ALU_ADD:  alu_res = sum;
      ALU_SUB:  alu_res = ex.alu_src_a_i - ex.alu_src_b_i;
      ALU_AND:  alu_res = ex.alu_src_a_i & ex.alu_src_b_i;
      ALU_OR:   alu_res = ex.alu_src_a_i | ex.alu_src_b_i;
      ALU_XOR:  alu_res = ex.alu_src_a_i ^ ex.alu_src_b_i;
      ALU_SLL:  alu_res = ex.alu_src_a_i << ex.alu_src_b_i[4:0];
      ALU_SRL:  alu_res = ex.alu_src_a_i >> ex.alu_src_b_i[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(ex.alu_src_a_i) >>> ex.alu_src_b_i[4:0]);
      ALU_SLT:  alu_res = {{(WORD_SIZE-1){1'b0}},
                           $signed(ex.alu_src_a_i) < $signed(ex.alu_src_b_i)};
      ALU_SLTU: alu_res = {{(WORD_SIZE-1){1'b0}}, ex.alu_src_a_i < ex.alu_src_b_i};
      ALU_LUI:  alu_res = ex.alu_src_b_i;
      ALU_BEQ:  taken = br_eq;
      ALU_BNE:  taken = ~br_eq;
      ALU_BLT:  taken = br_lt;
      ALU_BGE:  taken = ~br_lt;
      ALU_BLTU: taken = br_ltu;
      ALU_BGEU: taken = ~br_ltu;
      ALU_JAL:  taken = 1'b1;
      ALU_JALR: begin
        taken  = 1'b1;
        target = sum & ~32'd1;
      end
      default: begin
        alu_res = '0;
        taken   = 1'b0;
      end
    endcase
  end

  // Outside EX the enables drop to zero so each capture yields a one-cycle pulse;
  // data fields hold so the memory stage can keep using the address and store data.
  always_comb begin
    alu_res_d        = alu_res_q;
    rf_we_d          = 1'b0;
    rf_waddr_d       = rf_waddr_q;
    memop_type_d     = memop_type_q;
    memop_sign_ext_d = memop_sign_ext_q;
    memop_rd_d       = 1'b0;
    memop_wr_d       = 1'b0;
    memop_rf_data_d  = memop_rf_data_q;
    tkbr_d           = 1'b0;
    new_pc_d         = new_pc_q;
    if (ex.fsm_state_i == EX_STATE) begin
      alu_res_d        = ex.is_jaljalr_i ? ex.seq_new_pc_i : alu_res;
      rf_we_d          = ex.rf_we_i;
      rf_waddr_d       = ex.rf_waddr_i;
      memop_type_d     = ex.memop_type_i;
      memop_sign_ext_d = ex.memop_sign_ext_i;
      memop_rd_d       = ex.memop_rd_i;
      memop_wr_d       = ex.memop_wr_i;
      memop_rf_data_d  = ex.memop_rf_data_i;
      tkbr_d           = taken;
      new_pc_d         = target;
    end
  end

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      alu_res_q        <= '0;
      rf_we_q          <= 1'b0;
      rf_waddr_q       <= '0;
      memop_type_q     <= MEMOP_BYTE;
      memop_sign_ext_q <= 1'b0;
      memop_rd_q       <= 1'b0;
      memop_wr_q       <= 1'b0;
      memop_rf_data_q  <= '0;
      tkbr_q           <= 1'b0;
      new_pc_q         <= '0;
    end else begin
      alu_res_q        <= alu_res_d;
      rf_we_q          <= rf_we_d;
      rf_waddr_q       <= rf_waddr_d;
      memop_type_q     <= memop_type_d;
      memop_sign_ext_q <= memop_sign_ext_d;
      memop_rd_q       <= memop_rd_d;
      memop_wr_q       <= memop_wr_d;
      memop_rf_data_q  <= memop_rf_data_d;
      tkbr_q           <= tkbr_d;
      new_pc_q         <= new_pc_d;
    end
  end

  assign ex.alu_res_o        = alu_res_q;
  assign ex.rf_we_o          = rf_we_q;
  assign ex.rf_waddr_o       = rf_waddr_q;
  assign ex.memop_type_o     = memop_type_q;
  assign ex.memop_sign_ext_o = memop_sign_ext_q;
  assign ex.memop_rd_o       = memop_rd_q;
  assign ex.memop_wr_o       = memop_wr_q;
  assign ex.memop_rf_data_o  = memop_rf_data_q;
  assign ex.tkbr_o           = tkbr_q;
  assign ex.new_pc_o         = new_pc_q;

endmodule

// File: tb/tb_segre_ex_stage.sv
// tb/tb_segre_ex_stage.sv - scoreboard bench for segre_ex_stage with directed vectors
module tb_segre_ex_stage;
  import segre_pkg::*;

  typedef struct {
    int           cyc;
    logic [107:0] val;
    logic [107:0] mask;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  segre_ex_stage_if bus();
  segre_ex_stage dut (.clk_i(clk), .rsn_i(rst), .ex(bus));

  exp_t         sb[$];
  exp_t         e;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_mis = 0;
  logic [107:0] act;
  logic [107:0] last_val;
  logic [107:0] last_mask;
  logic [107:0] en_m;
  logic [107:0] all_m;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [107:0] pk(input logic [31:0] res, input logic we, input logic [4:0] wa,
                                      input logic [1:0] mt, input logic se, input logic rd,
                                      input logic wr, input logic [31:0] rfd, input logic tk,
                                      input logic [31:0] npc);
    return {res, we, wa, mt, se, rd, wr, rfd, tk, npc};
  endfunction

  // Monitor: every cycle, compare the outputs against whatever was queued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      act = pk(bus.alu_res_o, bus.rf_we_o, bus.rf_waddr_o, bus.memop_type_o, bus.memop_sign_ext_o,
               bus.memop_rd_o, bus.memop_wr_o, bus.memop_rf_data_o, bus.tkbr_o, bus.new_pc_o);
      if (e.cyc != cyc) begin
        n_mis++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
      end else if ((act & e.mask) !== (e.val & e.mask)) begin
        n_mis++;
        $display("FAIL %s: got %h required %h (mask %h)", e.name, act, e.val, e.mask);
      end
    end
  end

  function automatic void push(input logic [107:0] v, input logic [107:0] m, input string nm);
    exp_t x;
    x.cyc  = cyc + 1;
    x.val  = v;
    x.mask = m;
    x.name = nm;
    sb.push_back(x);
  endfunction

  task automatic drive(input fsm_state_e st, input alu_opcode_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ba, input logic [31:0] bb,
                       input logic we, input logic [4:0] wa, input memop_data_type_e mt,
                       input logic se, input logic rd, input logic wr, input logic [31:0] rfd,
                       input logic jj, input logic [31:0] seq);
    bus.fsm_state_i      = st;
    bus.alu_opcode_i     = op;
    bus.alu_src_a_i      = a;
    bus.alu_src_b_i      = b;
    bus.br_src_a_i       = ba;
    bus.br_src_b_i       = bb;
    bus.rf_we_i          = we;
    bus.rf_waddr_i       = wa;
    bus.memop_type_i     = mt;
    bus.memop_sign_ext_i = se;
    bus.memop_rd_i       = rd;
    bus.memop_wr_i       = wr;
    bus.memop_rf_data_i  = rfd;
    bus.is_jaljalr_i     = jj;
    bus.seq_new_pc_i     = seq;
  endtask

  // One EX capture; forwarded fields are expected to equal what was driven.
  task automatic ex(input string nm, input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ba, input logic [31:0] bb, input logic we, input logic [4:0] wa,
                    input memop_data_type_e mt, input logic se, input logic rd, input logic wr,
                    input logic [31:0] rfd, input logic jj, input logic [31:0] seq,
                    input logic [31:0] er, input logic rc, input logic et, input logic [31:0] enp,
                    input logic nc);
    logic [107:0] m;
    drive(EX_STATE, op, a, b, ba, bb, we, wa, mt, se, rd, wr, rfd, jj, seq);
    m = all_m;
    if (!rc) m = m & ~pk(32'hFFFFFFFF, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    if (!nc) m = m & ~pk(32'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hFFFFFFFF);
    last_val  = pk(er, we, wa, mt, se, rd, wr, rfd, et, enp);
    last_mask = m;
    push(last_val, m, nm);
    @(negedge clk);
  endtask

  task automatic alu(input string nm, input alu_opcode_e op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er);
    ex(nm, op, a, b, 32'h0, 32'h0, 1'b1, 5'd4, MEMOP_WORD, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
       er, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic br(input string nm, input alu_opcode_e op, input logic [31:0] ba, input logic [31:0] bb,
                    input logic [31:0] a, input logic [31:0] b, input logic tk, input logic [31:0] enp);
    ex(nm, op, a, b, ba, bb, 1'b0, 5'd0, MEMOP_WORD, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
       32'h0, 1'b0, tk, enp, tk);
  endtask

  // Non-EX cycle with busy inputs: data fields hold, enables read 0.
  task automatic hold(input string nm, input fsm_state_e st);
    drive(st, ALU_JAL, 32'h5555AAAA, 32'h1234, 32'h1, 32'h1, 1'b1, 5'd31, MEMOP_HALF, 1'b1, 1'b1,
          1'b1, 32'hCAFEF00D, 1'b1, 32'h7777);
    last_val = last_val & ~en_m;
    push(last_val, last_mask, nm);
    @(negedge clk);
  endtask

  initial begin
    en_m  = pk(32'h0, 1'b1, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0);
    all_m = '1;
    drive(IF_STATE, ALU_ADD, 0, 0, 0, 0, 0, 0, MEMOP_BYTE, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    push('0, all_m, "reset_initial");
    @(negedge clk);
    rst = 1'b0;

    alu("add_basic", ALU_ADD, 32'd1, 32'd2, 32'd3);

    // Reset asserted mid-cycle during an EX capture with rf_we_i high.
    drive(EX_STATE, ALU_ADD, 32'h10, 32'h20, 0, 0, 1'b1, 5'd7, MEMOP_WORD, 1'b1, 1'b1, 1'b1,
          32'h1111, 1'b0, 32'h0);
    push('0, all_m, "reset_async");
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    push('0, all_m, "reset_held");
    @(negedge clk);
    rst = 1'b0;
    last_val  = '0;
    last_mask = all_m;
    hold("hold_after_reset", ID_STATE);

    alu("sub_wrap",  ALU_SUB,  32'd5,        32'd7,        32'hFFFFFFFE);
    alu("sra_arith", ALU_SRA,  32'h80000000, 32'h21,       32'hC0000000);
    alu("srl",       ALU_SRL,  32'h80000000, 32'h4,        32'h08000000);
    alu("sll",       ALU_SLL,  32'h1,        32'h1F,       32'h80000000);
    alu("slt",       ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h1);
    alu("sltu",      ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0);
    alu("xor",       ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
    alu("and",       ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    alu("or",        ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
    alu("lui",       ALU_LUI,  32'h123,      32'hABCDE000, 32'hABCDE000);
    alu("unknown_op", alu_opcode_e'(5'd31), 32'h55, 32'h66, 32'h0);

    br("blt_taken",   ALU_BLT,  32'hFFFFFFFF, 32'h1, 32'h100, 32'h20,       1'b1, 32'h120);
    br("bltu_not",    ALU_BLTU, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20,       1'b0, 32'h0);
    br("beq_taken",   ALU_BEQ,  32'h7,        32'h7, 32'h400, 32'hFFFFFFF0, 1'b1, 32'h3F0);
    br("bne_not",     ALU_BNE,  32'h7,        32'h7, 32'h400, 32'hFFFFFFF0, 1'b0, 32'h0);
    br("bge_not",     ALU_BGE,  32'hFFFFFFFF, 32'h1, 32'h200, 32'h8,        1'b0, 32'h0);
    br("bgeu_taken",  ALU_BGEU, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h8,        1'b1, 32'h208);

    ex("jalr", ALU_JALR, 32'h1001, 32'h4, 0, 0, 1'b1, 5'd1, MEMOP_WORD, 0, 0, 0, 32'h0, 1'b1, 32'h208,
       32'h208, 1'b1, 1'b1, 32'h1004, 1'b1);
    ex("jal", ALU_JAL, 32'h100, 32'h11, 0, 0, 1'b1, 5'd2, MEMOP_WORD, 0, 0, 0, 32'h0, 1'b1, 32'h104,
       32'h104, 1'b1, 1'b1, 32'h111, 1'b1);

    ex("store", ALU_ADD, 32'h2000, 32'h8, 0, 0, 1'b0, 5'd0, MEMOP_WORD, 0, 0, 1'b1, 32'hDEADBEEF,
       1'b0, 32'h0, 32'h2008, 1'b1, 1'b0, 32'h0, 1'b0);
    hold("store_mem_hold", MEM_STATE);

    ex("load", ALU_ADD, 32'h3000, 32'hFFFFFFFC, 0, 0, 1'b1, 5'd9, MEMOP_HALF, 1'b1, 1'b1, 1'b0,
       32'h0, 1'b0, 32'h0, 32'h2FFC, 1'b1, 1'b0, 32'h0, 1'b0);
    hold("id_block_1", ID_STATE);
    hold("id_block_2", ID_STATE);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_mis += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
